// File: rtl/serializer_pkg.sv
// Shared types and constants for the serial-link transmitter (serializer_rl).
package serializer_pkg;
    localparam int DEFAULT_WIDTH = 8;

    localparam logic RL_LSB_FIRST = 1'b0;
    localparam logic RL_MSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/serializer_ctrl.sv
// Frame sequencer for serializer_rl: IDLE/SHIFT/DONE FSM with a bit counter,
// issuing load/shift strobes and the registered Busy/Done handshake.
module serializer_ctrl
    import serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic i_clk,
    input  logic i_srst,
    input  logic i_en,
    input  logic i_load,
    output logic o_load,
    output logic o_shift,
    output logic o_last,
    output logic o_busy,
    output logic o_done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;

    logic w_in_shift;
    logic w_last;

    assign w_in_shift = (r_state == SHIFT) && i_en;
    assign w_last     = w_in_shift && (r_cnt == LAST_CNT);

    assign o_load  = (r_state == IDLE) && i_en && i_load;
    assign o_shift = w_in_shift && !w_last;
    assign o_last  = w_last;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (o_load) begin
                        r_state <= SHIFT;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_last) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (i_en) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Leaves DONE regardless of En so Done is exactly one clock.
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/serializer_rl.sv
// Parallel-in serial-out transmitter: captures D on Load and sends it LSB- or
// MSB-first so a same-RL receiving shifter ends up holding the original word.
module serializer_rl
    import serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Load,
    input  logic             RL,
    input  logic [WIDTH-1:0] D,
    output logic             Out,
    output logic             Busy,
    output logic             Done
);
    logic [WIDTH-1:0] r_shreg;
    logic             r_rl;
    logic             r_out;

    logic [WIDTH-1:0] w_shift_next;
    logic             w_load;
    logic             w_shift;
    logic             w_last;
    logic             w_busy;
    logic             w_done;

    serializer_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .i_clk   (Clk),
        .i_srst  (Reset),
        .i_en    (En),
        .i_load  (Load),
        .o_load  (w_load),
        .o_shift (w_shift),
        .o_last  (w_last),
        .o_busy  (w_busy),
        .o_done  (w_done)
    );

    // Shift one place toward the output end; the vacated end fills with 0.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
        if (gi == 0) begin : g_lo
            assign w_shift_next[gi] = r_rl ? 1'b0 : r_shreg[gi+1];
        end else if (gi == WIDTH - 1) begin : g_hi
            assign w_shift_next[gi] = r_rl ? r_shreg[gi-1] : 1'b0;
        end else begin : g_mid
            assign w_shift_next[gi] = r_rl ? r_shreg[gi-1] : r_shreg[gi+1];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_shreg <= '0;
            r_rl    <= RL_LSB_FIRST;
            r_out   <= 1'b0;
        end else if (w_load) begin
            r_shreg <= D;
            r_rl    <= RL;
            r_out   <= (RL == RL_MSB_FIRST) ? D[WIDTH-1] : D[0];
        end else if (w_shift) begin
            r_shreg <= w_shift_next;
            r_out   <= (r_rl == RL_MSB_FIRST) ? w_shift_next[WIDTH-1] : w_shift_next[0];
        end else if (w_last) begin
            r_out   <= 1'b0;
        end
    end

    assign Out  = r_out;
    assign Busy = w_busy;
    assign Done = w_done;
endmodule

// File: tb/tb_serializer_rl.sv
// Self-checking bench for serializer_rl: directed frames plus random traffic
// compared cycle by cycle against a frame-level model and a looped-back receiver.
module tb_serializer_rl;
    localparam int W = 8;

    logic         Clk;
    logic         Reset;
    logic         En;
    logic         Load;
    logic         RL;
    logic [W-1:0] D;
    logic         Out;
    logic         Busy;
    logic         Done;

    int vectors;
    int miscompares;

    // Frame-level reference: which bit of which word is due, by index.
    bit           m_busy;
    bit           m_done;
    int           m_idx;
    logic [W-1:0] m_word;
    bit           m_rl;
    logic [W-1:0] rx;

    serializer_rl #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .En    (En),
        .Load  (Load),
        .RL    (RL),
        .D     (D),
        .Out   (Out),
        .Busy  (Busy),
        .Done  (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic exp_out();
        if (!m_busy) return 1'b0;
        return m_rl ? m_word[W-1-m_idx] : m_word[m_idx];
    endfunction

    // Called at a falling edge: drive inputs, advance the model across the
    // next rising edge, then compare at the following falling edge.
    task automatic step(input logic r, input logic e, input logic l,
                        input logic rl_i, input logic [W-1:0] d);
        Reset = r; En = e; Load = l; RL = rl_i; D = d;
        if (r) begin
            m_busy = 0; m_done = 0; m_idx = 0; m_rl = 0; m_word = '0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_busy) begin
            if (e) begin
                rx = m_rl ? {rx[W-2:0], Out} : {Out, rx[W-1:1]};
                if (m_idx == W - 1) begin
                    m_busy = 0;
                    m_done = 1;
                end else begin
                    m_idx++;
                end
            end
        end else if (l && e) begin
            m_busy = 1; m_idx = 0; m_word = d; m_rl = rl_i; rx = '0;
        end
        @(posedge Clk);
        @(negedge Clk);
        check("out", {31'd0, Out}, {31'd0, exp_out()});
        check("busy", {31'd0, Busy}, {31'd0, m_busy});
        check("done", {31'd0, Done}, {31'd0, m_done});
        if (m_done) check("rx_word", {24'd0, rx}, {24'd0, m_word});
    endtask

    task automatic send(input logic [W-1:0] d, input logic rl_i);
        step(0, 1, 1, rl_i, d);
        repeat (W + 2) step(0, 1, 0, 1'($urandom), W'($urandom));
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        m_busy = 0; m_done = 0; m_idx = 0; m_rl = 0; m_word = '0; rx = '0;
        Reset = 1; En = 0; Load = 0; RL = 0; D = '0;
        @(negedge Clk);

        repeat (3) step(1, 1, 1, 1, 8'hFF);
        repeat (4) step(0, 1, 0, 1, 8'hFF);

        send(8'hA5, 0);
        send(8'h3C, 1);

        step(0, 1, 1, 0, 8'hF0);
        for (int i = 0; i < 2 * W + 4; i++) step(0, (i % 2) == 1, 0, 1, 8'h0F);

        for (int i = 0; i < 3 * (W + 2); i++) step(0, 1, 1, 1'($urandom), W'($urandom));

        step(0, 1, 1, 0, 8'h96);
        repeat (4) step(0, 1, 0, 0, 8'h00);
        step(1, 1, 1, 1, 8'hFF);
        repeat (3) step(0, 1, 0, 0, 8'h00);
        send(8'h5B, 1);

        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) < 3), 1'($urandom), W'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
